pipe_stage_reg: RTL and testbench

- Parametrised pipeline boundary register for the five-stage CPU; generalised successor to the fixed MEM/WB latch.
- Carries NUM_CH data channels of DATA_W bits each across a stage boundary with a valid/ready handshake, a two-entry skid buffer, and a synchronous flush.
- The handshake lets the upstream stage stall without a combinational ready path.
- Instantiated between MEM and WB first; reusable for the IF/ID, ID/EX and EX/MEM boundaries.

---
 rtl/cpu_pipe_pkg.sv | 20 ++
 rtl/pipe_entry_reg.sv | 40 ++++
 rtl/pipe_stage_reg.sv | 136 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared constants for the five-stage CPU pipeline boundary registers.
package cpu_pipe_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    // MEM/WB channel packing
    localparam int unsigned CH_RDATA = 0;
    localparam int unsigned CH_ALU   = 1;
    localparam int unsigned CH_PC8   = 2;
    localparam int unsigned CH_INS   = 3;

    // Encoding equals the number of held entries
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: packed channel data plus valid bit, resetting/clearing to a bubble.
module pipe_entry_reg #(
    parameter int unsigned       DATA_W = 32,
    parameter int unsigned       NUM_CH = 4,
    parameter int unsigned       PC_CH  = 2,
    parameter logic [DATA_W-1:0] PC_RST = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     load_i,
    input  logic [DATA_W*NUM_CH-1:0] data_i,
    output logic [DATA_W*NUM_CH-1:0] data_o,
    output logic                     valid_o
);

    localparam int unsigned W = DATA_W * NUM_CH;
    localparam logic [W-1:0] BUBBLE = W'(PC_RST) << (PC_CH * DATA_W);

    logic [W-1:0] data_q;
    logic         valid_q;

    // Clear wins over load so a flush always leaves a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= BUBBLE;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            data_q  <= BUBBLE;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, two-entry skid buffer and flush.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W = 32,
    parameter int unsigned       NUM_CH = 4,
    parameter int unsigned       PC_CH  = 2,
    parameter logic [DATA_W-1:0] PC_RST = DATA_W'(PC_RESET)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W*NUM_CH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W*NUM_CH-1:0] out_data,
    output logic [1:0]               occupancy
);

    localparam int unsigned W = DATA_W * NUM_CH;

    if (PC_CH >= NUM_CH) begin : g_pc_ch_range
        $error("pipe_stage_reg: PC_CH must be less than NUM_CH");
    end

    pipe_state_e state_q, state_d;

    logic         main_load, main_clear, main_from_skid;
    logic         skid_load, skid_clear;
    logic [W-1:0] main_d;
    logic [W-1:0] main_q, skid_q;
    logic         main_valid_q, skid_valid_q;
    logic         accept, drain;

    assign accept = in_valid & ~skid_valid_q;
    assign drain  = main_valid_q & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                    state_d   = TWO;
                end else if (drain) begin
                    main_clear = 1'b1;
                    state_d    = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                    state_d        = ONE;
                end
            end
            default: begin
                main_clear = 1'b1;
                skid_clear = 1'b1;
                state_d    = EMPTY;
            end
        endcase

        // Flush drops everything, including a beat offered this cycle
        if (flush) begin
            main_load  = 1'b0;
            skid_load  = 1'b0;
            main_clear = 1'b1;
            skid_clear = 1'b1;
            state_d    = EMPTY;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .PC_CH  (PC_CH),
        .PC_RST (PC_RST)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .clear_i (main_clear),
        .load_i  (main_load),
        .data_i  (main_d),
        .data_o  (main_q),
        .valid_o (main_valid_q)
    );

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .PC_CH  (PC_CH),
        .PC_RST (PC_RST)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clear_i (skid_clear),
        .load_i  (skid_load),
        .data_i  (in_data),
        .data_o  (skid_q),
        .valid_o (skid_valid_q)
    );

    assign out_data  = main_q;
    assign out_valid = main_valid_q;
    assign in_ready  = ~skid_valid_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default 4x32 instance plus a 1x16 parameter-sweep instance.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;

    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_data, out_data;
    logic [1:0]   occupancy;

    logic         in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0]  in_data16, out_data16;
    logic [1:0]   occupancy16;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] BUBBLE   = {32'h0, 32'h0000_3000, 32'h0, 32'h0};
    localparam logic [15:0]  BUBBLE16 = 16'h0100;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_stage_reg #(
        .DATA_W (16),
        .NUM_CH (1),
        .PC_CH  (0),
        .PC_RST (16'h0100)
    ) dut16 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_data   (in_data16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_data  (out_data16),
        .occupancy (occupancy16)
    );

    // Beat with instruction channel = v and distinct patterns in the others
    function automatic logic [127:0] mk(input logic [31:0] v);
        return {v, v + 32'h100, ~v, v << 4};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic v, input logic r,
                              input logic [1:0] occ, input logic [127:0] d);
        check({tag, ".valid"}, 128'(out_valid), 128'(v));
        check({tag, ".ready"}, 128'(in_ready), 128'(r));
        check({tag, ".occ"},   128'(occupancy), 128'(occ));
        check({tag, ".data"},  out_data, d);
    endtask

    task automatic check_16(input string tag, input logic v, input logic r,
                            input logic [1:0] occ, input logic [15:0] d);
        check({tag, ".valid"}, 128'(out_valid16), 128'(v));
        check({tag, ".ready"}, 128'(in_ready16), 128'(r));
        check({tag, ".occ"},   128'(occupancy16), 128'(occ));
        check({tag, ".data"},  128'(out_data16), 128'(d));
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_data     = '0;
        in_valid16  = 1'b0;
        out_ready16 = 1'b0;
        in_data16   = '0;

        #2;
        check_main("reset", 1'b0, 1'b1, 2'd0, BUBBLE);
        check_16("reset16", 1'b0, 1'b1, 2'd0, BUBBLE16);
        tick();
        rst = 1'b0;

        // Streaming, back to back
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = mk(32'h11);
        tick();
        check_main("stream11", 1'b1, 1'b1, 2'd1, mk(32'h11));
        in_data = mk(32'h22);
        tick();
        check_main("stream22", 1'b1, 1'b1, 2'd1, mk(32'h22));
        in_data = mk(32'h33);
        tick();
        check_main("stream33", 1'b1, 1'b1, 2'd1, mk(32'h33));
        in_data = mk(32'h44);
        tick();
        check_main("stream44", 1'b1, 1'b1, 2'd1, mk(32'h44));
        in_valid = 1'b0;
        tick();
        check_main("stream_end", 1'b0, 1'b1, 2'd0, BUBBLE);

        // Skid capture and stall hold
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = mk(32'hA1);
        tick();
        check_main("skid_one", 1'b1, 1'b1, 2'd1, mk(32'hA1));
        in_data = mk(32'hB2);
        tick();
        check_main("skid_two", 1'b1, 1'b0, 2'd2, mk(32'hA1));
        in_data = mk(32'hEE);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_main("stall", 1'b1, 1'b0, 2'd2, mk(32'hA1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_main("skid_drainB2", 1'b1, 1'b1, 2'd1, mk(32'hB2));
        tick();
        check_main("skid_empty", 1'b0, 1'b1, 2'd0, BUBBLE);

        // Flush against an accept while holding one entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = mk(32'hA1);
        tick();
        flush   = 1'b1;
        in_data = mk(32'hC3);
        tick();
        check_main("flush_occ1", 1'b0, 1'b1, 2'd0, BUBBLE);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check_main("flush_occ1_after", 1'b0, 1'b1, 2'd0, BUBBLE);

        // Flush colliding with accept and drain while full
        in_valid = 1'b1;
        in_data  = mk(32'hA1);
        tick();
        in_data = mk(32'hB2);
        tick();
        check_main("pre_flush_two", 1'b1, 1'b0, 2'd2, mk(32'hA1));
        flush     = 1'b1;
        in_data   = mk(32'hC3);
        out_ready = 1'b1;
        tick();
        check_main("flush_occ2", 1'b0, 1'b1, 2'd0, BUBBLE);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check_main("flush_occ2_after", 1'b0, 1'b1, 2'd0, BUBBLE);

        // Asynchronous reset mid-stream with two entries held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = mk(32'h55);
        tick();
        in_data = mk(32'h66);
        tick();
        check_main("pre_rst_two", 1'b1, 1'b0, 2'd2, mk(32'h55));
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_main("async_rst", 1'b0, 1'b1, 2'd0, BUBBLE);
        check_16("async_rst16", 1'b0, 1'b1, 2'd0, BUBBLE16);
        tick();
        rst = 1'b0;

        // Narrow single-channel instance: streaming then skid
        out_ready16 = 1'b1;
        in_valid16  = 1'b1;
        in_data16   = 16'h0011;
        tick();
        check_16("s16_11", 1'b1, 1'b1, 2'd1, 16'h0011);
        in_data16 = 16'h0022;
        tick();
        check_16("s16_22", 1'b1, 1'b1, 2'd1, 16'h0022);
        in_data16 = 16'h0033;
        tick();
        check_16("s16_33", 1'b1, 1'b1, 2'd1, 16'h0033);
        in_valid16 = 1'b0;
        tick();
        check_16("s16_end", 1'b0, 1'b1, 2'd0, BUBBLE16);
        out_ready16 = 1'b0;
        in_valid16  = 1'b1;
        in_data16   = 16'h00A1;
        tick();
        check_16("k16_one", 1'b1, 1'b1, 2'd1, 16'h00A1);
        in_data16 = 16'h00B2;
        tick();
        check_16("k16_two", 1'b1, 1'b0, 2'd2, 16'h00A1);
        in_valid16  = 1'b0;
        out_ready16 = 1'b1;
        tick();
        check_16("k16_B2", 1'b1, 1'b1, 2'd1, 16'h00B2);
        tick();
        check_16("k16_empty", 1'b0, 1'b1, 2'd0, BUBBLE16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
